smooth_filter_ctrl: RTL and testbench
=====================================

SMOOTH_FILTER_CTRL -- requirements
Module: smooth_filter_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 250000, sample period in clk cycles (legal 2..524287).
REQ-002 Parameter FLT_LAT, default 1, filter latency in cycles from en to valid flt_out (legal 1..4).
REQ-003 clk  input  1  system clock, single clock domain.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 sw_req  input  2  window select from board switches, asynchronous to clk.
REQ-006 flt_out  input  16  smoothed sample from the shared filter.
REQ-007 ds_ready  input  1  downstream ready.
REQ-008 sw_out  output  2  registered window select driven to the filter.
REQ-009 en  output  1  one-cycle sample strobe to the filter.
REQ-010 count  output  19  tick counter value, for debug.
REQ-011 data_out  output  16  captured filter result.
REQ-012 data_valid  output  1  data_out valid; held until accepted.
REQ-013 filling  output  1  high while the window is refilling.

Function
REQ-014 count increments every cycle and wraps from TICK_DIV-1 to 0; en SHALL be 1 exactly in cycles where count==TICK_DIV-1.
REQ-015 Window length W SHALL be 2<<sw_out: 2, 4, 8 or 16 samples.
REQ-016 sw_req SHALL pass through a 2-flop synchronizer before use; sw_sync is the synchronized value.
REQ-017 FSM has two states, FILL and RUN; filling==1 in FILL only.
REQ-018 In FILL, each en increments a fill counter; on the en that raises it to W, the state SHALL become RUN.
REQ-019 Capture strobe cap SHALL be en delayed by FLT_LAT cycles, tagged "deliver" when that en was issued in RUN or was the W-th fill en.
REQ-020 On a clock edge with cap && deliver: data_out<=flt_out and data_valid<=1.
REQ-021 data_valid && ds_ready on an edge SHALL clear data_valid unless a capture occurs on the same edge; in that case the capture wins and data_valid stays 1.
REQ-022 A capture while data_valid && !ds_ready SHALL overwrite data_out (newest sample wins).
REQ-023 When sw_sync != sw_out: sw_out<=sw_sync, fill counter<=0, state<=FILL, data_valid<=0, all in-flight deliver tags cleared; count is not disturbed.
REQ-024 If a mode change and en coincide, en SHALL still be issued, but that en is not counted toward the new fill.
REQ-025 A mode change during FILL SHALL restart the fill under the new W.

Reset
REQ-026 Asserting reset (low) SHALL immediately force count=0, en=0, sw_out=0, data_out=0, data_valid=0, filling=1, state=FILL, fill counter=0, synchronizer flops=0, and clear the cap pipeline.
REQ-027 After reset deasserts, the first en SHALL occur TICK_DIV cycles later; reset mid-fill or mid-handshake discards all state.

Configuration
REQ-028 Macro SMOOTH_CTRL_OVERRUN_EN: when defined, add output overrun (1 bit), set sticky by any REQ-022 overwrite and cleared only by reset.
REQ-029 When SMOOTH_CTRL_OVERRUN_EN is undefined, the overrun port and its logic SHALL be absent; REQ-022 overwrite behaviour is unchanged.

Verification (TICK_DIV=10, FLT_LAT=1)
REQ-030 Release reset, sw_req=00 -> en at cycles 10, 20, 30 after release; first data_valid the cycle after the 2nd en; filling falls with the 2nd en.
REQ-031 sw_req=11, ds_ready=1 -> no data_valid for the first 15 en; data_valid pulses one cycle after the 16th en and after every en thereafter, each lasting one cycle.
REQ-032 In RUN, set ds_ready=0 across two captures with flt_out=0x0032 then 0x0064 -> data_out=0x0064, data_valid held at 1, overrun=1 (macro defined); overrun remains 1 after ds_ready=1.
REQ-033 In RUN, change sw_req 00->01 timed so sw_sync changes on an en cycle -> en still pulses, data_valid drops, 4 further en are required before the next data_valid, and count is not disturbed.
REQ-034 Assert reset low mid-fill and mid-handshake (data_valid=1) -> all outputs take their reset values asynchronously, before the next clk edge.
REQ-035 ds_ready=1 on the same edge as a new capture -> data_valid stays 1 and data_out shows the new sample.

Source files
------------

// File: rtl/smooth_filter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : smooth_filter_ctrl
// Brief    : Sample-tick generator, window-fill FSM and capture handshake for a
//            shared smoothing filter. Optional macro SMOOTH_CTRL_OVERRUN_EN adds
//            a sticky overrun output.
// Revision : 1.0 - initial release
// ============================================================================
module smooth_filter_ctrl #(
    parameter int TICK_DIV = 250000,
    parameter int FLT_LAT  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  sw_req,
    input  logic [15:0] flt_out,
    input  logic        ds_ready,
    output logic [1:0]  sw_out,
    output logic        en,
    output logic [18:0] count,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic        filling
`ifdef SMOOTH_CTRL_OVERRUN_EN
    ,
    output logic        overrun
`endif
);

    localparam logic [18:0] c_tick_max = 19'(TICK_DIV - 1);

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               state_q;
    logic [18:0]          count_q;
    logic [18:0]          count_d;
    logic                 en_q;
    logic [1:0]           sync1_q;
    logic [1:0]           sync2_q;
    logic [1:0]           sw_out_q;
    logic [4:0]           fill_q;
    logic [15:0]          data_out_q;
    logic                 data_valid_q;
    logic [FLT_LAT-1:0]   dlv_q;
    logic [FLT_LAT-1:0]   dlv_d;
`ifdef SMOOTH_CTRL_OVERRUN_EN
    logic                 overrun_q;
`endif

    logic                 w_mode_chg;
    logic [4:0]           w_win;
    logic [4:0]           w_fill_inc;
    logic                 w_tag;
    logic                 w_cap;

    always_comb begin
        count_d    = (count_q == c_tick_max) ? 19'd0 : count_q + 19'd1;
        w_mode_chg = (sync2_q != sw_out_q);
        w_win      = 5'd2 << sw_out_q;
        w_fill_inc = fill_q + 5'd1;
        // An en coinciding with a mode change is issued but never delivered.
        w_tag      = en_q && !w_mode_chg &&
                     ((state_q == RUN) || (w_fill_inc == w_win));
        dlv_d      = '0;
        dlv_d[0]   = w_tag;
        for (int i = 1; i < FLT_LAT; i++) begin
            dlv_d[i] = dlv_q[i-1];
        end
        if (w_mode_chg) begin
            dlv_d = '0;
        end
        w_cap      = dlv_q[FLT_LAT-1] && !w_mode_chg;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q      <= '0;
            en_q         <= 1'b0;
            sync1_q      <= '0;
            sync2_q      <= '0;
            sw_out_q     <= '0;
            fill_q       <= '0;
            state_q      <= FILL;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            dlv_q        <= '0;
`ifdef SMOOTH_CTRL_OVERRUN_EN
            overrun_q    <= 1'b0;
`endif
        end else begin
            count_q <= count_d;
            en_q    <= (count_d == c_tick_max);
            sync1_q <= sw_req;
            sync2_q <= sync1_q;
            dlv_q   <= dlv_d;
            if (w_mode_chg) begin
                sw_out_q     <= sync2_q;
                fill_q       <= '0;
                state_q      <= FILL;
                data_valid_q <= 1'b0;
            end else begin
                if (en_q && (state_q == FILL)) begin
                    fill_q <= w_fill_inc;
                    if (w_fill_inc == w_win) begin
                        state_q <= RUN;
                    end
                end
                // A new capture beats a same-edge handshake and overwrites unread data.
                if (w_cap) begin
                    data_out_q   <= flt_out;
                    data_valid_q <= 1'b1;
`ifdef SMOOTH_CTRL_OVERRUN_EN
                    if (data_valid_q && !ds_ready) begin
                        overrun_q <= 1'b1;
                    end
`endif
                end else if (data_valid_q && ds_ready) begin
                    data_valid_q <= 1'b0;
                end
            end
        end
    end

    assign count      = count_q;
    assign en         = en_q;
    assign sw_out     = sw_out_q;
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign filling    = (state_q == FILL);
`ifdef SMOOTH_CTRL_OVERRUN_EN
    assign overrun    = overrun_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_smooth_filter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_smooth_filter_ctrl
// Brief    : Directed self-checking bench for smooth_filter_ctrl
//            (TICK_DIV=10, FLT_LAT=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_smooth_filter_ctrl;

    logic        clk;
    logic        reset;
    logic [1:0]  sw_req;
    logic [15:0] flt_out;
    logic        ds_ready;
    logic [1:0]  sw_out;
    logic        en;
    logic [18:0] count;
    logic [15:0] data_out;
    logic        data_valid;
    logic        filling;
`ifdef SMOOTH_CTRL_OVERRUN_EN
    logic        overrun;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int k        = 0;

    smooth_filter_ctrl #(
        .TICK_DIV (10),
        .FLT_LAT  (1)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .sw_req     (sw_req),
        .flt_out    (flt_out),
        .ds_ready   (ds_ready),
        .sw_out     (sw_out),
        .en         (en),
        .count      (count),
        .data_out   (data_out),
        .data_valid (data_valid),
        .filling    (filling)
`ifdef SMOOTH_CTRL_OVERRUN_EN
        ,
        .overrun    (overrun)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, k, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        k++;
    endtask

    task automatic check_cycle(input logic e_fill, input logic e_dv, input logic [1:0] e_sw);
        check("count",      32'(count),      32'(k % 10));
        check("en",         32'(en),         32'(k % 10 == 9));
        check("filling",    32'(filling),    32'(e_fill));
        check("data_valid", 32'(data_valid), 32'(e_dv));
        check("sw_out",     32'(sw_out),     32'(e_sw));
    endtask

    task automatic check_reset_vals();
        check("rst_count",      32'(count),      32'd0);
        check("rst_en",         32'(en),         32'd0);
        check("rst_sw_out",     32'(sw_out),     32'd0);
        check("rst_data_out",   32'(data_out),   32'd0);
        check("rst_data_valid", 32'(data_valid), 32'd0);
        check("rst_filling",    32'(filling),    32'd1);
`ifdef SMOOTH_CTRL_OVERRUN_EN
        check("rst_overrun",    32'(overrun),    32'd0);
`endif
    endtask

    initial begin
        reset    = 1'b0;
        sw_req   = 2'b00;
        flt_out  = 16'h0000;
        ds_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals();

        // W=2: en every 10 cycles, delivery from the second en onward
        reset   = 1'b1;
        k       = 0;
        flt_out = 16'hA000;
        for (int i = 1; i <= 40; i++) begin
            step();
            check_cycle(k < 20, (k >= 21) && (k % 10 == 1), 2'd0);
            if ((k >= 21) && (k % 10 == 1))
                check("data_out_w2", 32'(data_out), 32'(16'hA000 + 16'(k - 1)));
            if (k == 20)
                check("data_out_idle", 32'(data_out), 32'd0);
            flt_out = 16'hA000 + 16'(k);
        end

        // W=16: sixteen fill ens before the first new delivery
        sw_req = 2'b11;
        for (int i = 41; i <= 230; i++) begin
            step();
            check_cycle((k >= 43) && (k < 200),
                        (k % 10 == 1) && ((k == 41) || (k >= 201)),
                        (k >= 43) ? 2'd3 : 2'd0);
            if ((k >= 201) && (k % 10 == 1))
                check("data_out_w16", 32'(data_out), 32'(16'hA000 + 16'(k - 1)));
            flt_out = 16'hA000 + 16'(k);
        end

        // Back-pressure across two captures: newest sample wins
        for (int i = 231; i <= 260; i++) begin
            step();
            check_cycle(1'b0, (k == 231) || (k >= 241), 2'd3);
            if ((k >= 241) && (k <= 250))
                check("data_out_ovw1", 32'(data_out), 32'h0032);
            if (k >= 251)
                check("data_out_ovw2", 32'(data_out), 32'h0064);
`ifdef SMOOTH_CTRL_OVERRUN_EN
            check("overrun", 32'(overrun), 32'(k >= 251));
`endif
            if (k == 232) ds_ready = 1'b0;
            if (k == 240) flt_out = 16'h0032;
            if (k == 250) flt_out = 16'h0064;
        end
        ds_ready = 1'b1;
        flt_out  = 16'h0077;

        // Same-edge handshake+capture, then mode change on an en cycle
        for (int i = 261; i <= 325; i++) begin
            step();
            check_cycle((k >= 280) && (k < 320),
                        (k == 261) || ((k >= 271) && (k <= 279)) || (k >= 321),
                        (k >= 280) ? 2'd1 : 2'd3);
            if (k == 261)
                check("data_out_same_edge", 32'(data_out), 32'h0077);
            if ((k >= 271) && (k <= 279))
                check("data_out_held", 32'(data_out), 32'(16'hA000 + 16'd270));
            if (k >= 321)
                check("data_out_w4", 32'(data_out), 32'(16'hA000 + 16'd320));
`ifdef SMOOTH_CTRL_OVERRUN_EN
            check("overrun_sticky", 32'(overrun), 32'd1);
`endif
            flt_out = 16'hA000 + 16'(k);
            if (k == 270) ds_ready = 1'b0;
            if (k == 277) sw_req = 2'b01;
        end

        // Asynchronous reset mid-handshake, then mid-fill
        reset = 1'b0;
        #1;
        check_reset_vals();
        @(negedge clk);
        reset = 1'b1;
        k     = 0;
        for (int i = 1; i <= 15; i++) begin
            step();
            check_cycle(1'b1, 1'b0, (k >= 3) ? 2'd1 : 2'd0);
        end
        reset = 1'b0;
        #1;
        check_reset_vals();
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
